// File: rtl/sd_blk_responder.sv
// sd_blk_responder: four-drive SD block server streaming 512-byte blocks to/from a byte-wide image memory.
// Arbitration is fixed priority (drive 0 highest) unless SDBLK_RR_ARB_EN is defined, which selects round-robin.
module sd_blk_responder #(
    parameter int MEM_AW     = 22,
    parameter int DRIVE_BLKS = 2048
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [31:0]       sd_lba [4],
    input  logic [3:0]        sd_rd,
    input  logic [3:0]        sd_wr,
    output logic [3:0]        sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    input  logic [7:0]        sd_buff_din [4],
    output logic              sd_buff_wr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              oor
);
    localparam int LBA_W = MEM_AW - 11;

    typedef enum logic [2:0] {
        IDLE, GRANT, RD_MEM, RD_BUF, WR_ADDR, WR_CAP, WR_MEM, DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [3:0]       req;
    logic [1:0]       pick;
    logic [1:0]       ch;
    logic             oor_f;
    logic [LBA_W-1:0] lba;
    logic [8:0]       idx;
    logic [7:0]       rbyte;
    logic [7:0]       wbyte;
    logic             last;
    logic             mem_done;

    assign req      = sd_rd | sd_wr;
    assign last     = (idx == 9'd511);
    // Out-of-range blocks never touch memory, so they complete as if ready were high.
    assign mem_done = mem_ready || oor_f;

`ifdef SDBLK_RR_ARB_EN
    logic [1:0] rr_ptr;

    always_comb begin
        logic found;
        found = 1'b0;
        pick  = rr_ptr;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && req[rr_ptr + 2'(i)]) begin
                pick  = rr_ptr + 2'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            rr_ptr <= '0;
        else if (state == GRANT)
            rr_ptr <= ch + 2'd1;
    end
`else
    always_comb begin
        logic found;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && req[i]) begin
                pick  = 2'(i);
                found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = GRANT;
            GRANT:   state_nx = sd_rd[ch] ? RD_MEM : WR_ADDR;
            RD_MEM:  if (mem_done) state_nx = RD_BUF;
            RD_BUF:  state_nx = last ? DONE : RD_MEM;
            WR_ADDR: state_nx = WR_CAP;
            WR_CAP:  state_nx = WR_MEM;
            WR_MEM:  if (mem_done) state_nx = last ? DONE : WR_ADDR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ch     <= '0;
            oor_f  <= 1'b0;
            lba    <= '0;
            idx    <= '0;
            rbyte  <= '0;
            wbyte  <= '0;
            sd_ack <= '0;
        end else begin
            case (state)
                IDLE: if (|req) ch <= pick;
                GRANT: begin
                    sd_ack <= 4'b0001 << ch;
                    lba    <= sd_lba[ch][LBA_W-1:0];
                    oor_f  <= (sd_lba[ch] >= 32'(DRIVE_BLKS));
                    idx    <= '0;
                end
                RD_MEM: if (mem_done) rbyte <= oor_f ? 8'h00 : mem_rdata;
                RD_BUF: if (!last) idx <= idx + 9'd1;
                WR_CAP: wbyte <= sd_buff_din[ch];
                WR_MEM: if (mem_done && !last) idx <= idx + 9'd1;
                DONE:   sd_ack <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        sd_buff_wr = 1'b0;
        oor        = 1'b0;
        busy       = (state != IDLE);
        case (state)
            RD_MEM:  mem_rd     = !oor_f;
            RD_BUF:  sd_buff_wr = 1'b1;
            WR_MEM:  mem_wr     = !oor_f;
            DONE:    oor        = oor_f;
            default: ;
        endcase
    end

    assign mem_addr     = {ch, lba, idx};
    assign mem_wdata    = wbyte;
    assign sd_buff_addr = idx;
    assign sd_buff_dout = rbyte;

endmodule

// File: tb/tb_sd_blk_responder.sv
// Directed bench for sd_blk_responder: reads, writes, out-of-range blocks, wait states, arbitration and reset.
module tb_sd_blk_responder;
    localparam int MEM_AW     = 22;
    localparam int DRIVE_BLKS = 315;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic [31:0]       sd_lba [4];
    logic [3:0]        sd_rd = '0;
    logic [3:0]        sd_wr = '0;
    logic [3:0]        sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic [7:0]        sd_buff_din [4];
    logic              sd_buff_wr;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;
    logic              busy;
    logic              oor;

    int n_cmp  = 0;
    int n_fail = 0;

    sd_blk_responder #(.MEM_AW(MEM_AW), .DRIVE_BLKS(DRIVE_BLKS)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .oor(oor)
    );

    always #5 CLK = ~CLK;

    logic [55:0] all_outs;
    assign all_outs = {sd_ack, busy, mem_rd, mem_wr, sd_buff_wr, oor,
                       mem_addr, sd_buff_addr, sd_buff_dout, mem_wdata};

    // Memory model: image byte equals address low byte; optional two wait cycles per access.
    logic       wait_mode = 1'b0;
    logic [1:0] wcnt = '0;
    assign mem_ready = !wait_mode || (wcnt == 2'd2);
    assign mem_rdata = mem_addr[7:0];
    always @(posedge CLK) begin
        if ((mem_rd || mem_wr) && !mem_ready) wcnt <= wcnt + 2'd1;
        else wcnt <= 2'd0;
    end

    // Buffer model: one-cycle read latency; non-requesting drives return 0xEE.
    int   bdrive = 0;
    logic bmode  = 1'b0;
    function automatic logic [7:0] pat(input logic [8:0] a);
        return a[7:0] ^ 8'h3C ^ {a[8], 7'b0};
    endfunction
    always @(posedge CLK) begin
        for (int n = 0; n < 4; n++)
            sd_buff_din[n] <= (n == bdrive) ? (bmode ? pat(sd_buff_addr) : 8'hA5) : 8'hEE;
    end

    int                obs_ack, obs_lat, obs_nb, obs_nm, obs_rd_cyc, obs_wr_cyc, obs_oor, obs_ackbad;
    bit                obs_timeout;
    logic [8:0]        obs_baddr [1024];
    logic [7:0]        obs_bdata [1024];
    logic [MEM_AW-1:0] obs_maddr [1024];
    logic [7:0]        obs_mdata [1024];

    // Raise a request and record everything observed until its ack falls.
    task automatic do_xfer(input int drv, input bit rd, input bit wr, input logic [31:0] lba);
        bit seen;
        int k;
        obs_ack = 0; obs_lat = -1; obs_nb = 0; obs_nm = 0;
        obs_rd_cyc = 0; obs_wr_cyc = 0; obs_oor = 0; obs_ackbad = 0;
        seen = 1'b0;
        @(negedge CLK);
        sd_lba[drv] = lba;
        bdrive = drv;
        if (rd) sd_rd[drv] = 1'b1;
        if (wr) sd_wr[drv] = 1'b1;
        for (k = 1; k <= 6000; k++) begin
            @(negedge CLK);
            if (sd_ack != 4'b0000) begin
                if (!seen) obs_lat = k;
                seen = 1'b1;
                obs_ack++;
                if (sd_ack != (4'b0001 << drv)) obs_ackbad++;
            end else if (seen) begin
                break;
            end
            if (sd_buff_wr) begin
                if (obs_nb < 1024) begin
                    obs_baddr[obs_nb] = sd_buff_addr;
                    obs_bdata[obs_nb] = sd_buff_dout;
                end
                obs_nb++;
            end
            if ((mem_rd || mem_wr) && mem_ready) begin
                if (obs_nm < 1024) begin
                    obs_maddr[obs_nm] = mem_addr;
                    obs_mdata[obs_nm] = mem_wdata;
                end
                obs_nm++;
            end
            if (mem_rd) obs_rd_cyc++;
            if (mem_wr) obs_wr_cyc++;
            if (oor) obs_oor++;
        end
        obs_timeout = (k > 6000);
        sd_rd[drv] = 1'b0;
        sd_wr[drv] = 1'b0;
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL reset_idle_outputs: got %h expected 0", all_outs);
        end
    endtask

    task automatic test_read;
        wait_mode = 1'b0;
        do_xfer(1, 1'b1, 1'b0, 32'd3);
        n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL read_timeout: got 1 expected 0"); end
        n_cmp++; if (obs_lat !== 2) begin n_fail++; $display("FAIL read_ack_latency: got %0d expected 2", obs_lat); end
        n_cmp++; if (obs_ack !== 1025) begin n_fail++; $display("FAIL read_ack_len: got %0d expected 1025", obs_ack); end
        n_cmp++; if (obs_ackbad !== 0) begin n_fail++; $display("FAIL read_ack_onehot: got %0d bad cycles expected 0", obs_ackbad); end
        n_cmp++; if (obs_nb !== 512) begin n_fail++; $display("FAIL read_buf_pulses: got %0d expected 512", obs_nb); end
        n_cmp++; if (obs_nm !== 512) begin n_fail++; $display("FAIL read_mem_acc: got %0d expected 512", obs_nm); end
        n_cmp++; if (obs_oor !== 0) begin n_fail++; $display("FAIL read_oor: got %0d expected 0", obs_oor); end
        for (int i = 0; i < 512; i++) begin
            n_cmp++;
            if (obs_baddr[i] !== 9'(i)) begin
                n_fail++; $display("FAIL read_buf_addr[%0d]: got %0d expected %0d", i, obs_baddr[i], i);
            end
            n_cmp++;
            if (obs_bdata[i] !== 8'(i)) begin
                n_fail++; $display("FAIL read_buf_data[%0d]: got %h expected %h", i, obs_bdata[i], 8'(i));
            end
            n_cmp++;
            if (obs_maddr[i] !== 22'(32'h100600 + i)) begin
                n_fail++; $display("FAIL read_mem_addr[%0d]: got %h expected %h", i, obs_maddr[i], 22'(32'h100600 + i));
            end
        end
    endtask

    task automatic test_write;
        bmode = 1'b0;
        do_xfer(2, 1'b0, 1'b1, 32'd0);
        n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL write_timeout: got 1 expected 0"); end
        n_cmp++; if (obs_ack !== 1537) begin n_fail++; $display("FAIL write_ack_len: got %0d expected 1537", obs_ack); end
        n_cmp++; if (obs_nm !== 512) begin n_fail++; $display("FAIL write_mem_acc: got %0d expected 512", obs_nm); end
        n_cmp++; if (obs_wr_cyc !== 512) begin n_fail++; $display("FAIL write_strobe_cycles: got %0d expected 512", obs_wr_cyc); end
        n_cmp++; if (obs_nb !== 0) begin n_fail++; $display("FAIL write_buf_pulses: got %0d expected 0", obs_nb); end
        for (int i = 0; i < 512; i++) begin
            n_cmp++;
            if (obs_mdata[i] !== 8'hA5) begin
                n_fail++; $display("FAIL write_data[%0d]: got %h expected a5", i, obs_mdata[i]);
            end
            n_cmp++;
            if (obs_maddr[i] !== 22'(32'h200000 + i)) begin
                n_fail++; $display("FAIL write_mem_addr[%0d]: got %h expected %h", i, obs_maddr[i], 22'(32'h200000 + i));
            end
        end
    endtask

    task automatic test_rd_wr_both;
        do_xfer(0, 1'b1, 1'b1, 32'd9);
        n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL both_timeout: got 1 expected 0"); end
        n_cmp++; if (obs_nb !== 512) begin n_fail++; $display("FAIL both_buf_pulses: got %0d expected 512", obs_nb); end
        n_cmp++; if (obs_wr_cyc !== 0) begin n_fail++; $display("FAIL both_mem_wr: got %0d expected 0", obs_wr_cyc); end
        n_cmp++; if (obs_ack !== 1025) begin n_fail++; $display("FAIL both_ack_len: got %0d expected 1025", obs_ack); end
        n_cmp++; if (obs_maddr[0] !== 22'h001200) begin n_fail++; $display("FAIL both_first_addr: got %h expected 001200", obs_maddr[0]); end
        n_cmp++; if (obs_maddr[511] !== 22'h0013FF) begin n_fail++; $display("FAIL both_last_addr: got %h expected 0013ff", obs_maddr[511]); end
    endtask

    task automatic test_out_of_range;
        do_xfer(0, 1'b1, 1'b0, 32'd315);
        n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL oor_timeout: got 1 expected 0"); end
        n_cmp++; if (obs_ack !== 1025) begin n_fail++; $display("FAIL oor_ack_len: got %0d expected 1025", obs_ack); end
        n_cmp++; if (obs_nb !== 512) begin n_fail++; $display("FAIL oor_buf_pulses: got %0d expected 512", obs_nb); end
        n_cmp++; if (obs_rd_cyc !== 0) begin n_fail++; $display("FAIL oor_mem_rd: got %0d expected 0", obs_rd_cyc); end
        n_cmp++; if (obs_oor !== 1) begin n_fail++; $display("FAIL oor_pulse: got %0d expected 1", obs_oor); end
        for (int i = 0; i < 512; i++) begin
            n_cmp++;
            if (obs_bdata[i] !== 8'h00) begin
                n_fail++; $display("FAIL oor_data[%0d]: got %h expected 00", i, obs_bdata[i]);
            end
        end
        do_xfer(0, 1'b1, 1'b0, 32'd314);
        n_cmp++; if (obs_oor !== 0) begin n_fail++; $display("FAIL inrange_oor: got %0d expected 0", obs_oor); end
        n_cmp++; if (obs_nm !== 512) begin n_fail++; $display("FAIL inrange_mem_acc: got %0d expected 512", obs_nm); end
        n_cmp++; if (obs_bdata[1] !== 8'h01) begin n_fail++; $display("FAIL inrange_data: got %h expected 01", obs_bdata[1]); end
        do_xfer(3, 1'b0, 1'b1, 32'h8000_0000);
        n_cmp++; if (obs_wr_cyc !== 0) begin n_fail++; $display("FAIL oor_wr_strobe: got %0d expected 0", obs_wr_cyc); end
        n_cmp++; if (obs_ack !== 1537) begin n_fail++; $display("FAIL oor_wr_ack_len: got %0d expected 1537", obs_ack); end
        n_cmp++; if (obs_oor !== 1) begin n_fail++; $display("FAIL oor_wr_pulse: got %0d expected 1", obs_oor); end
    endtask

    task automatic test_wait_states;
        wait_mode = 1'b1;
        do_xfer(3, 1'b1, 1'b0, 32'd6);
        wait_mode = 1'b0;
        n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL wait_timeout: got 1 expected 0"); end
        n_cmp++; if (obs_ack !== 2049) begin n_fail++; $display("FAIL wait_ack_len: got %0d expected 2049", obs_ack); end
        n_cmp++; if (obs_nb !== 512) begin n_fail++; $display("FAIL wait_buf_pulses: got %0d expected 512", obs_nb); end
        n_cmp++; if (obs_rd_cyc !== 1536) begin n_fail++; $display("FAIL wait_strobe_cycles: got %0d expected 1536", obs_rd_cyc); end
        n_cmp++; if (obs_maddr[0] !== 22'h300C00) begin n_fail++; $display("FAIL wait_first_addr: got %h expected 300c00", obs_maddr[0]); end
        for (int i = 0; i < 512; i++) begin
            n_cmp++;
            if (obs_bdata[i] !== 8'(i)) begin
                n_fail++; $display("FAIL wait_data[%0d]: got %h expected %h", i, obs_bdata[i], 8'(i));
            end
        end
    endtask

    task automatic test_arbitration;
        logic [3:0] grants [5];
        logic [3:0] prev;
        logic [3:0] exp_g;
        int         ng;
        ng = 0;
        prev = '0;
        @(negedge CLK);
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int d = 0; d < 4; d++) sd_lba[d] = 32'd1;
        sd_rd = 4'b1111;
        for (int k = 0; k < 7000; k++) begin
            @(negedge CLK);
            if (sd_ack != 4'b0000 && prev == 4'b0000 && ng < 5) begin
                grants[ng] = sd_ack;
                ng++;
            end
            prev = sd_ack;
            if (ng == 5 && sd_ack == 4'b0000) break;
        end
        sd_rd = 4'b0000;
        n_cmp++; if (ng !== 5) begin n_fail++; $display("FAIL arb_grant_count: got %0d expected 5", ng); end
        for (int g = 0; g < 5; g++) begin
            if (g < ng) begin
`ifdef SDBLK_RR_ARB_EN
                exp_g = 4'b0001 << (g % 4);
`else
                exp_g = 4'b0001;
`endif
                n_cmp++;
                if (grants[g] !== exp_g) begin
                    n_fail++; $display("FAIL arb_grant[%0d]: got %b expected %b", g, grants[g], exp_g);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int nw;
        int k;
        nw = 0;
        bmode = 1'b1;
        @(negedge CLK);
        bdrive = 3;
        sd_lba[3] = 32'd7;
        sd_wr[3] = 1'b1;
        for (k = 0; k < 2000; k++) begin
            @(negedge CLK);
            if (mem_wr && mem_ready) nw++;
            if (nw == 100) break;
        end
        n_cmp++; if (nw !== 100) begin n_fail++; $display("FAIL midrst_progress: got %0d expected 100", nw); end
        #2 RESET_N = 1'b0;
        #1;
        n_cmp++;
        if (all_outs !== '0) begin
            n_fail++; $display("FAIL midrst_async_outputs: got %h expected 0", all_outs);
        end
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        do_xfer(3, 1'b0, 1'b1, 32'd7);
        n_cmp++; if (obs_timeout) begin n_fail++; $display("FAIL midrst_timeout: got 1 expected 0"); end
        n_cmp++; if (obs_ack !== 1537) begin n_fail++; $display("FAIL midrst_ack_len: got %0d expected 1537", obs_ack); end
        n_cmp++; if (obs_nm !== 512) begin n_fail++; $display("FAIL midrst_mem_acc: got %0d expected 512", obs_nm); end
        for (int i = 0; i < 512; i++) begin
            n_cmp++;
            if (obs_maddr[i] !== 22'(32'h300E00 + i)) begin
                n_fail++; $display("FAIL midrst_addr[%0d]: got %h expected %h", i, obs_maddr[i], 22'(32'h300E00 + i));
            end
            n_cmp++;
            if (obs_mdata[i] !== pat(9'(i))) begin
                n_fail++; $display("FAIL midrst_data[%0d]: got %h expected %h", i, obs_mdata[i], pat(9'(i)));
            end
        end
        bmode = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 4; d++) sd_lba[d] = '0;
        test_reset();
        test_read();
        test_write();
        test_rd_wr_both();
        test_out_of_range();
        test_wait_states();
        test_arbitration();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_blk_responder.md
# sd_blk_responder

Block-level responder for the four-drive SD block interface used by the floppy controller. It arbitrates the per-drive `sd_rd`/`sd_wr` requests and asserts the matching `sd_ack`. It streams one 512-byte block between the requesting drive's sector buffer and a byte-wide backing image memory (RAM disk, SDRAM port or simulation model). It sits in place of the HPS block server, for RAM-disk builds and for closed-loop verification of the controller.

## Interface
- `MEM_AW`, 22: backing memory byte-address width. Each drive owns a 2^(MEM_AW-2)-byte region.
- `DRIVE_BLKS`, 2048: number of valid blocks per drive. Must be ≤ 2^(MEM_AW-11).

Ports:
- `CLK`  in  1: system clock, all logic rising-edge.
- `RESET_N`  in  1: reset, asynchronous, active-low.
- `sd_lba[4]`  in  32 each: block address per drive, valid while that drive's request is high.
- `sd_rd`  in  4: per-drive read request (level).
- `sd_wr`  in  4: per-drive write request (level).
- `sd_ack`  out  4: per-drive acknowledge, one-hot or zero.
- `sd_buff_addr`  out  9: byte index into the requester's buffer.
- `sd_buff_dout`  out  8: read data toward the requester's buffer.
- `sd_buff_din[4]`  in  8 each: per-drive buffer read data, one-cycle latency from `sd_buff_addr`.
- `sd_buff_wr`  out  1: buffer write strobe.
- `mem_addr`  out  MEM_AW: backing memory address.
- `mem_rd`, `mem_wr`  out  1: memory strobes, held until `mem_ready`.
- `mem_wdata`  out  8: memory write data.
- `mem_rdata`  in  8: memory read data, valid in the cycle `mem_ready` is high.
- `mem_ready`  in  1: memory completion.
- `busy`  out  1: high in every state other than IDLE.
- `oor`  out  1: one-cycle pulse in DONE when the served LBA was out of range.

## Operation
- **States:** IDLE, GRANT, RD_MEM, RD_BUF, WR_ADDR, WR_CAP, WR_MEM, DONE.
- **IDLE:**
  - A drive is eligible when `sd_rd[n]|sd_wr[n]` is high.
  - Arbitration picks one eligible drive, `ch`. If both `sd_rd[ch]` and `sd_wr[ch]` are high, the read is served.
  - Transition to GRANT.
- **GRANT:**
  - `sd_ack[ch]`=1.
  - Latch `lba = sd_lba[ch]`, direction, and `oor_f = (lba >= DRIVE_BLKS)`.
  - Set `idx`=0.
  - Transition to RD_MEM or WR_ADDR.
- **Address map:** `mem_addr = {ch[1:0], lba[MEM_AW-12:0], idx[8:0]}`. Upper LBA bits are ignored beyond the range check.
- **Read loop:**
  - RD_MEM asserts `mem_rd` and captures `mem_rdata` on `mem_ready`, then moves to RD_BUF.
  - RD_BUF pulses `sd_buff_wr`, drives `sd_buff_addr=idx` and `sd_buff_dout`=captured byte.
  - If `idx`==511, go to DONE. Otherwise `idx`++ and return to RD_MEM.
- **Write loop:**
  - WR_ADDR drives `sd_buff_addr=idx`.
  - WR_CAP captures `sd_buff_din[ch]`.
  - WR_MEM asserts `mem_wr` with `mem_wdata`=captured byte until `mem_ready`.
  - If `idx`==511, go to DONE. Otherwise `idx`++ and return to WR_ADDR.
- **Out of range (`oor_f`=1):**
  - `mem_rd`/`mem_wr` are never asserted; RD_MEM/WR_MEM complete as if `mem_ready` were high.
  - Reads deliver 0x00 bytes; write data is discarded.
- **DONE:**
  - `sd_ack`=0.
  - `oor` pulses if `oor_f`.
  - Transition to IDLE.
  - A request still high in IDLE is treated as a new request.
- **Ack ownership:** `sd_ack` changes only in GRANT and DONE. The requester must keep `sd_lba` stable while its ack is high.
- **Other drives:** requests from other drives during a transfer wait and are not dropped.

## Timing
- **Reset values:** all outputs 0, state IDLE, round-robin pointer 0. Asynchronous reset mid-transfer aborts immediately; the memory must tolerate abandoned strobes.
- **Request to ack:** `sd_ack` rises two edges after the request is first sampled high in IDLE.
- **Ack duration with `mem_ready` tied high:**
  - Read: ack high 1+1024 cycles (GRANT + 2 per byte).
  - Write: ack high 1+1536 cycles (3 per byte).
  - Each `mem_ready` wait cycle adds one cycle.
- **Write data capture:** `sd_buff_din` is sampled exactly one cycle after its address is presented.
- **`idx` width:** 9 bits. The loop terminates on 511 and never wraps into a second block.

## Configuration
- `SDBLK_RR_ARB_EN` defined: round-robin arbitration. The search starts at the drive after the last granted drive, and the pointer updates in GRANT.
- Undefined: fixed priority, drive 0 highest, drive 3 lowest.

## Test plan
- **Read:** drive 1, lba=3, memory preloaded with byte = addr[7:0], ready high.
  - Expect 512 `sd_buff_wr` pulses, addr 0..511, data (0x00..0xFF)×2.
  - Expect `mem_addr` 0x100600..0x1007FF.
  - Expect `sd_ack[1]` high for 1025 cycles.
- **Write:** drive 2, lba=0, buffer holds 0xA5 at every address.
  - Expect 512 `mem_wr` with `mem_wdata`=0xA5 at 0x200000..0x2001FF.
  - Expect ack high for 1537 cycles.
- **Arbitration:** `sd_rd`=4'b1111 held.
  - Fixed priority: drive 0 is re-granted after every DONE.
  - With `SDBLK_RR_ARB_EN`: grants go 0,1,2,3,0.
- **Out of range:** `DRIVE_BLKS`=315, read lba=315.
  - Expect 512 bytes of 0x00, `mem_rd` never high, and `oor` pulsing once.
- **Wait states:** `mem_ready` low for 2 cycles per access on a read.
  - Expect ack duration 2049 cycles and data intact.
- **Reset mid-transfer:** assert `RESET_N`=0 at byte 100 of a write.
  - Expect all outputs 0 immediately.
  - After release with the request still high, expect a full transfer from `idx` 0.
